// File: rtl/input_port.sv
// rtl/input_port.sv - NoC router input port: per-VC flit FIFOs, packet FSMs and XY routing
package noc_params;
    localparam int MESH_SIZE_X      = 4;
    localparam int MESH_SIZE_Y      = 4;
    localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X);
    localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y);
    localparam int VC_NUM           = 2;
    localparam int VC_SIZE          = $clog2(VC_NUM);
    localparam int PAYLOAD_SIZE     = 16;

    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;
    typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;

    typedef struct packed {
        flit_label_t                 flit_label;
        logic [VC_SIZE-1:0]          vc_id;
        logic [DEST_ADDR_SIZE_X-1:0] x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
        logic [PAYLOAD_SIZE-1:0]     payload;
    } flit_t;
endpackage

module input_port
    import noc_params::*;
#(
    parameter int BUFFER_SIZE = 8,
    parameter int X_CURRENT   = MESH_SIZE_X / 2,
    parameter int Y_CURRENT   = MESH_SIZE_Y / 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  flit_t                          data_i,
    input  logic                           valid_flit_i,
    input  logic [VC_SIZE-1:0]             sa_sel_vc_i,
    input  logic                           sa_valid_i,
    input  logic [VC_NUM-1:0][VC_SIZE-1:0] va_new_vc_i,
    input  logic [VC_NUM-1:0]              va_valid_i,
    output flit_t                          xb_flit_o,
    output logic [VC_NUM-1:0]              is_on_off_o,
    output logic [VC_NUM-1:0]              is_allocatable_vc_o,
    output logic [VC_NUM-1:0]              va_request_o,
    output logic [VC_NUM-1:0]              sa_request_o,
    output logic [VC_NUM-1:0][VC_SIZE-1:0] sa_downstream_vc_o,
    output port_t [VC_NUM-1:0]             out_port_o,
    output logic [VC_NUM-1:0]              is_full_o,
    output logic [VC_NUM-1:0]              is_empty_o,
    output logic [VC_NUM-1:0]              error_o
);
    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_VA, S_SA} vc_state_e;

    flit_t              mem_q    [VC_NUM][BUFFER_SIZE];
    vc_state_e          state_q  [VC_NUM];
    vc_state_e          state_d  [VC_NUM];
    logic [PTR_W-1:0]   rd_ptr_q [VC_NUM];
    logic [PTR_W-1:0]   rd_ptr_d [VC_NUM];
    logic [PTR_W-1:0]   wr_ptr_q [VC_NUM];
    logic [PTR_W-1:0]   wr_ptr_d [VC_NUM];
    logic [CNT_W-1:0]   count_q  [VC_NUM];
    logic [CNT_W-1:0]   count_d  [VC_NUM];
    logic [VC_SIZE-1:0] dvc_q    [VC_NUM];
    logic [VC_SIZE-1:0] dvc_d    [VC_NUM];
    port_t              port_q   [VC_NUM];
    port_t              port_d   [VC_NUM];
    logic [VC_NUM-1:0]  err_q, err_d;

    logic              in_head;
    logic [VC_NUM-1:0] wr_hit, rd_hit, pop, room, store;

    function automatic port_t xy_route(input flit_t f);
        if (int'(f.x_dest) > X_CURRENT)      return EAST;
        else if (int'(f.x_dest) < X_CURRENT) return WEST;
        else if (int'(f.y_dest) > Y_CURRENT) return SOUTH;
        else if (int'(f.y_dest) < Y_CURRENT) return NORTH;
        else                                 return LOCAL;
    endfunction

    assign in_head = (data_i.flit_label == HEAD) || (data_i.flit_label == HEADTAIL);

    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
            wr_hit[v] = valid_flit_i && (data_i.vc_id == VC_SIZE'(v));
            rd_hit[v] = sa_valid_i && (sa_sel_vc_i == VC_SIZE'(v));
            pop[v]    = rd_hit[v] && (state_q[v] == S_SA) && (count_q[v] != '0);
            // A full FIFO still accepts a flit when the head leaves in the same cycle
            room[v]   = (count_q[v] != CNT_W'(BUFFER_SIZE)) || pop[v];
            store[v]  = wr_hit[v] && room[v] && ((state_q[v] == S_IDLE) == in_head);

            state_d[v]  = state_q[v];
            dvc_d[v]    = dvc_q[v];
            port_d[v]   = port_q[v];
            rd_ptr_d[v] = rd_ptr_q[v] + PTR_W'(pop[v]);
            wr_ptr_d[v] = wr_ptr_q[v] + PTR_W'(store[v]);
            count_d[v]  = count_q[v] + CNT_W'(store[v]) - CNT_W'(pop[v]);
            err_d[v]    = err_q[v] | (wr_hit[v] & ~store[v]) | (rd_hit[v] & ~pop[v]);

            case (state_q[v])
                S_IDLE: if (store[v]) begin
                    state_d[v] = S_VA;
                    port_d[v]  = xy_route(data_i);
                end
                S_VA: if (va_valid_i[v]) begin
                    state_d[v] = S_SA;
                    dvc_d[v]   = va_new_vc_i[v];
                end
                S_SA: if (pop[v] && ((mem_q[v][rd_ptr_q[v]].flit_label == TAIL) ||
                                     (mem_q[v][rd_ptr_q[v]].flit_label == HEADTAIL)))
                    state_d[v] = S_IDLE;
                default: state_d[v] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                state_q[v]  <= S_IDLE;
                rd_ptr_q[v] <= '0;
                wr_ptr_q[v] <= '0;
                count_q[v]  <= '0;
                dvc_q[v]    <= '0;
                port_q[v]   <= LOCAL;
            end
            err_q <= '0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                state_q[v]  <= state_d[v];
                rd_ptr_q[v] <= rd_ptr_d[v];
                wr_ptr_q[v] <= wr_ptr_d[v];
                count_q[v]  <= count_d[v];
                dvc_q[v]    <= dvc_d[v];
                port_q[v]   <= port_d[v];
            end
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++)
            if (store[v]) mem_q[v][wr_ptr_q[v]] <= data_i;
    end

    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
            is_empty_o[v]          = (count_q[v] == '0);
            is_full_o[v]           = (count_q[v] == CNT_W'(BUFFER_SIZE));
            is_on_off_o[v]         = (count_q[v] <= CNT_W'(BUFFER_SIZE - 2));
            is_allocatable_vc_o[v] = (state_q[v] == S_IDLE) && (count_q[v] == '0);
            va_request_o[v]        = (state_q[v] == S_VA);
            sa_request_o[v]        = (state_q[v] == S_SA) && (count_q[v] != '0);
            sa_downstream_vc_o[v]  = dvc_q[v];
            out_port_o[v]          = port_q[v];
            error_o[v]             = err_q[v];
        end
        xb_flit_o       = mem_q[sa_sel_vc_i][rd_ptr_q[sa_sel_vc_i]];
        xb_flit_o.vc_id = dvc_q[sa_sel_vc_i];
    end
endmodule

// File: tb/tb_input_port.sv
// tb/tb_input_port.sv - self-checking bench for input_port
module tb_input_port;
    import noc_params::*;

    localparam int B  = 8;
    localparam int XC = 2;
    localparam int YC = 2;

    typedef logic [VC_NUM-1:0][VC_SIZE-1:0] nvc_t;

    typedef struct {
        logic        vf;
        flit_label_t lab;
        logic [15:0] pay;
        logic        vav;
        logic        sav;
        logic        exp_pop;
        flit_label_t exp_lab;
        logic [15:0] exp_pay;
        logic        exp_va;
        logic        exp_sa;
        logic        exp_empty;
        logic        exp_alloc;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    rst;
    flit_t                   data_i;
    logic                    valid_flit_i;
    logic [VC_SIZE-1:0]      sa_sel_vc_i;
    logic                    sa_valid_i;
    nvc_t                    va_new_vc_i;
    logic [VC_NUM-1:0]       va_valid_i;
    flit_t                   xb_flit_o;
    logic [VC_NUM-1:0]       is_on_off_o, is_allocatable_vc_o, va_request_o, sa_request_o;
    nvc_t                    sa_downstream_vc_o;
    port_t [VC_NUM-1:0]      out_port_o;
    logic [VC_NUM-1:0]       is_full_o, is_empty_o, error_o;

    input_port #(.BUFFER_SIZE(B), .X_CURRENT(XC), .Y_CURRENT(YC)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_flit_i(valid_flit_i),
        .sa_sel_vc_i(sa_sel_vc_i), .sa_valid_i(sa_valid_i),
        .va_new_vc_i(va_new_vc_i), .va_valid_i(va_valid_i),
        .xb_flit_o(xb_flit_o), .is_on_off_o(is_on_off_o),
        .is_allocatable_vc_o(is_allocatable_vc_o), .va_request_o(va_request_o),
        .sa_request_o(sa_request_o), .sa_downstream_vc_o(sa_downstream_vc_o),
        .out_port_o(out_port_o), .is_full_o(is_full_o), .is_empty_o(is_empty_o),
        .error_o(error_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int rr    = 0;

    // Reference model: 0 = waiting for head, 1 = waiting for VC grant, 2 = granted
    flit_t              mq    [VC_NUM][$];
    int                 mst   [VC_NUM];
    logic [VC_SIZE-1:0] mdvc  [VC_NUM];
    port_t              mport [VC_NUM];
    logic               merr  [VC_NUM];
    flit_t              delivered [$];
    flit_t              xb_pre;
    logic               saw_full;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic port_t ref_route(input flit_t f);
        int dx, dy;
        dx = int'(f.x_dest) - XC;
        dy = int'(f.y_dest) - YC;
        if (dx > 0) return EAST;
        if (dx < 0) return WEST;
        if (dy > 0) return SOUTH;
        if (dy < 0) return NORTH;
        return LOCAL;
    endfunction

    function automatic flit_t mkf(input int v, input flit_label_t l, input int x, input int y, input int p);
        flit_t f;
        f.flit_label = l;
        f.vc_id      = VC_SIZE'(v);
        f.x_dest     = DEST_ADDR_SIZE_X'(x);
        f.y_dest     = DEST_ADDR_SIZE_Y'(y);
        f.payload    = PAYLOAD_SIZE'(p);
        return f;
    endfunction

    function automatic bit can_pop(input int v);
        return mst[v] == 2 && mq[v].size() > 0;
    endfunction

    function automatic int pick_sel(input int start);
        for (int k = 0; k < VC_NUM; k++)
            if (can_pop((start + k) % VC_NUM)) return (start + k) % VC_NUM;
        return start;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < VC_NUM; v++) begin
            mq[v].delete();
            mst[v]   = 0;
            mdvc[v]  = '0;
            mport[v] = LOCAL;
            merr[v]  = 1'b0;
        end
    endtask

    task automatic check_status();
        int n;
        for (int v = 0; v < VC_NUM; v++) begin
            n = mq[v].size();
            if (is_full_o[v]) saw_full = 1'b1;
            chk($sformatf("empty[%0d]", v),  64'(is_empty_o[v]),          64'(n == 0));
            chk($sformatf("full[%0d]", v),   64'(is_full_o[v]),           64'(n == B));
            chk($sformatf("onoff[%0d]", v),  64'(is_on_off_o[v]),         64'(n <= B - 2));
            chk($sformatf("alloc[%0d]", v),  64'(is_allocatable_vc_o[v]), 64'(mst[v] == 0 && n == 0));
            chk($sformatf("va_req[%0d]", v), 64'(va_request_o[v]),        64'(mst[v] == 1));
            chk($sformatf("sa_req[%0d]", v), 64'(sa_request_o[v]),        64'(mst[v] == 2 && n > 0));
            chk($sformatf("dvc[%0d]", v),    64'(sa_downstream_vc_o[v]),  64'(mdvc[v]));
            chk($sformatf("port[%0d]", v),   64'(out_port_o[v]),          64'(mport[v]));
            chk($sformatf("error[%0d]", v),  64'(error_o[v]),             64'(merr[v]));
        end
    endtask

    task automatic cyc(input logic vf, input flit_t d, input logic sav, input logic [VC_SIZE-1:0] sel,
                       input logic [VC_NUM-1:0] vav, input nvc_t nvc);
        int    pre [VC_NUM];
        int    s, w, szw;
        bit    do_pop, head, legal;
        flit_t f;
        valid_flit_i = vf; data_i = d; sa_valid_i = sav; sa_sel_vc_i = sel;
        va_valid_i = vav; va_new_vc_i = nvc;
        #1;
        xb_pre = xb_flit_o;
        s = int'(sel);
        w = int'(d.vc_id);
        szw = mq[w].size();
        for (int v = 0; v < VC_NUM; v++) pre[v] = mst[v];
        do_pop = sav && pre[s] == 2 && mq[s].size() > 0;
        if (do_pop) begin
            f = mq[s][0];
            f.vc_id = mdvc[s];
            chk("xb_flit", 64'(xb_flit_o), 64'(f));
            delivered.push_back(f);
            void'(mq[s].pop_front());
            if (f.flit_label == TAIL || f.flit_label == HEADTAIL) mst[s] = 0;
        end else if (sav) begin
            merr[s] = 1'b1;
        end
        if (vf) begin
            head  = d.flit_label == HEAD || d.flit_label == HEADTAIL;
            legal = (pre[w] == 0) ? head : !head;
            if (szw >= B && !(do_pop && s == w)) legal = 0;
            if (legal) begin
                mq[w].push_back(d);
                if (pre[w] == 0) begin
                    mst[w]   = 1;
                    mport[w] = ref_route(d);
                end
            end else begin
                merr[w] = 1'b1;
            end
        end
        for (int v = 0; v < VC_NUM; v++)
            if (pre[v] == 1 && vav[v]) begin
                mst[v]  = 2;
                mdvc[v] = nvc[v];
            end
        @(posedge clk);
        #1;
        check_status();
    endtask

    // Directed step: optional write, switch allocation grants any VC that is requesting
    task automatic step(input logic vf, input int v, input flit_label_t l, input int p,
                        input logic [VC_NUM-1:0] vav, input nvc_t nvc);
        int sel;
        rr  = (rr + 1) % VC_NUM;
        sel = pick_sel(rr);
        cyc(vf, mkf(v, l, 3, 1, p), can_pop(sel), VC_SIZE'(sel), vav, nvc);
    endtask

    task automatic do_reset();
        rst = 1'b1; valid_flit_i = 1'b0; sa_valid_i = 1'b0; va_valid_i = '0;
        data_i = '0; sa_sel_vc_i = '0; va_new_vc_i = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        delivered.delete();
        saw_full = 1'b0;
        check_status();
    endtask

    initial begin
        vec_t              tbl [8];
        flit_label_t       exp4 [4];
        nvc_t              nvc;
        logic [VC_NUM-1:0] vav;
        logic              vf, sav;
        flit_label_t       l;
        int                v, w, sel, c0, c1, badvc;

        tbl[0] = '{1'b1, HEAD, 16'hA000, 1'b0, 1'b0, 1'b0, HEAD, 16'h0,     1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, BODY, 16'hA001, 1'b0, 1'b0, 1'b0, HEAD, 16'h0,     1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, BODY, 16'hA002, 1'b1, 1'b0, 1'b0, HEAD, 16'h0,     1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, TAIL, 16'hA003, 1'b0, 1'b1, 1'b1, HEAD, 16'hA000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, BODY, 16'h0,     1'b0, 1'b1, 1'b1, BODY, 16'hA001, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, BODY, 16'h0,     1'b0, 1'b1, 1'b1, BODY, 16'hA002, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, BODY, 16'h0,     1'b0, 1'b1, 1'b1, TAIL, 16'hA003, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{1'b0, BODY, 16'h0,     1'b0, 1'b0, 1'b0, TAIL, 16'h0,     1'b0, 1'b0, 1'b1, 1'b1};

        do_reset();
        chk("rst_empty",  64'(is_empty_o),          64'({VC_NUM{1'b1}}));
        chk("rst_onoff",  64'(is_on_off_o),         64'({VC_NUM{1'b1}}));
        chk("rst_alloc",  64'(is_allocatable_vc_o), 64'({VC_NUM{1'b1}}));
        chk("rst_full",   64'(is_full_o),           64'(0));
        chk("rst_req",    64'({va_request_o, sa_request_o}), 64'(0));
        chk("rst_error",  64'(error_o),             64'(0));
        chk("rst_dvc",    64'(sa_downstream_vc_o),  64'(0));
        chk("rst_port",   64'(out_port_o),          64'(0));

        // 4-flit packet from the vector table
        v = $urandom_range(0, VC_NUM - 1);
        for (int i = 0; i < 8; i++) begin
            nvc = '0; nvc[v] = VC_SIZE'(1);
            vav = tbl[i].vav ? (VC_NUM'(1) << v) : '0;
            cyc(tbl[i].vf, mkf(v, tbl[i].lab, 3, 1, int'(tbl[i].pay)), tbl[i].sav, VC_SIZE'(v), vav, nvc);
            if (i == 0) chk("tbl_port", 64'(out_port_o[v]), 64'(EAST));
            if (tbl[i].exp_pop) begin
                chk($sformatf("tbl%0d_label", i), 64'(xb_pre.flit_label), 64'(tbl[i].exp_lab));
                chk($sformatf("tbl%0d_pay", i),   64'(xb_pre.payload),    64'(tbl[i].exp_pay));
                chk($sformatf("tbl%0d_vc", i),    64'(xb_pre.vc_id),      64'(1));
            end
            chk($sformatf("tbl%0d_va", i),    64'(va_request_o[v]),        64'(tbl[i].exp_va));
            chk($sformatf("tbl%0d_sa", i),    64'(sa_request_o[v]),        64'(tbl[i].exp_sa));
            chk($sformatf("tbl%0d_empty", i), 64'(is_empty_o[v]),          64'(tbl[i].exp_empty));
            chk($sformatf("tbl%0d_alloc", i), 64'(is_allocatable_vc_o[v]), 64'(tbl[i].exp_alloc));
        end
        chk("tbl_error", 64'(error_o[v]), 64'(0));

        // Spaced packet: two idle cycles after each flit
        do_reset();
        v = $urandom_range(0, VC_NUM - 1);
        nvc = '0; nvc[v] = VC_SIZE'(1);
        exp4[0] = HEAD; exp4[1] = BODY; exp4[2] = BODY; exp4[3] = TAIL;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, v, exp4[i], 16'hB000 + i, (i == 1) ? (VC_NUM'(1) << v) : '0, nvc);
            step(1'b0, v, BODY, 0, '0, nvc);
            step(1'b0, v, BODY, 0, '0, nvc);
        end
        for (int i = 0; i < 3; i++) step(1'b0, v, BODY, 0, '0, nvc);
        chk("sp_count", 64'(delivered.size()), 64'(4));
        for (int i = 0; i < delivered.size() && i < 4; i++)
            chk($sformatf("sp_label%0d", i), 64'(delivered[i].flit_label), 64'(exp4[i]));
        chk("sp_error", 64'(error_o[v]), 64'(0));

        // 16-flit packet streamed through the 8-deep FIFO
        do_reset();
        v = $urandom_range(0, VC_NUM - 1);
        nvc = '0; nvc[v] = VC_SIZE'(1);
        for (int i = 0; i < 16; i++)
            step(1'b1, v, (i == 0) ? HEAD : (i == 15) ? TAIL : BODY, i,
                 (i == 1) ? (VC_NUM'(1) << v) : '0, nvc);
        for (int i = 0; i < 4; i++) step(1'b0, v, BODY, 0, '0, nvc);
        chk("long_count", 64'(delivered.size()), 64'(16));
        for (int i = 0; i < delivered.size() && i < 16; i++)
            chk($sformatf("long_pay%0d", i), 64'(delivered[i].payload), 64'(i));
        chk("long_full", 64'(saw_full), 64'(0));
        chk("long_error", 64'(error_o), 64'(0));
        chk("long_alloc", 64'(is_allocatable_vc_o[v]), 64'(1));

        // Repeated HEADs: only the first one is kept
        do_reset();
        v = $urandom_range(0, VC_NUM - 1);
        nvc = '0;
        for (int i = 0; i < 7; i++)
            step(1'b1, v, (i < 4) ? HEAD : (i == 6) ? TAIL : BODY, 16'hC000 + i,
                 (i == 1) ? (VC_NUM'(1) << v) : '0, nvc);
        for (int i = 0; i < 4; i++) step(1'b0, v, BODY, 0, '0, nvc);
        chk("hh_count", 64'(delivered.size()), 64'(4));
        for (int i = 0; i < delivered.size() && i < 4; i++)
            chk($sformatf("hh_label%0d", i), 64'(delivered[i].flit_label), 64'(exp4[i]));
        chk("hh_error", 64'(error_o[v]), 64'(1));

        // HEADTAIL single flit
        do_reset();
        v = $urandom_range(0, VC_NUM - 1);
        step(1'b1, v, HEADTAIL, 16'hD00D, VC_NUM'(0), nvc);
        step(1'b0, v, BODY, 0, VC_NUM'(1) << v, nvc);
        step(1'b0, v, BODY, 0, '0, nvc);
        chk("ht_count", 64'(delivered.size()), 64'(1));
        chk("ht_alloc", 64'(is_allocatable_vc_o[v]), 64'(1));
        chk("ht_error", 64'(error_o[v]), 64'(0));

        // BODY and TAIL while IDLE are dropped
        do_reset();
        v = $urandom_range(0, VC_NUM - 1);
        step(1'b1, v, BODY, 1, '0, nvc);
        step(1'b1, v, TAIL, 2, '0, nvc);
        chk("idle_empty", 64'(is_empty_o[v]), 64'(1));
        chk("idle_error", 64'(error_o[v]), 64'(1));

        // Two VCs interleaved on the link
        do_reset();
        nvc = '0; nvc[0] = VC_SIZE'(1); nvc[1] = VC_SIZE'(0);
        step(1'b1, 0, HEAD, 16'h0000, '0, nvc);
        step(1'b1, 1, HEAD, 16'h1000, '0, nvc);
        step(1'b1, 0, BODY, 16'h0001, VC_NUM'(1), nvc);
        step(1'b1, 1, BODY, 16'h1001, VC_NUM'(2), nvc);
        step(1'b1, 0, BODY, 16'h0002, '0, nvc);
        step(1'b1, 1, BODY, 16'h1002, '0, nvc);
        step(1'b1, 0, TAIL, 16'h0003, '0, nvc);
        step(1'b1, 1, BODY, 16'h1003, '0, nvc);
        step(1'b1, 1, TAIL, 16'h1004, '0, nvc);
        for (int i = 0; i < 8; i++) step(1'b0, 0, BODY, 0, '0, nvc);
        c0 = 0; c1 = 0; badvc = 0;
        foreach (delivered[i]) begin
            if (delivered[i].payload[15:12] == 4'h0) begin
                c0++; if (delivered[i].vc_id != VC_SIZE'(1)) badvc++;
            end else begin
                c1++; if (delivered[i].vc_id != VC_SIZE'(0)) badvc++;
            end
        end
        chk("two_vc0_count", 64'(c0), 64'(4));
        chk("two_vc1_count", 64'(c1), 64'(5));
        chk("two_vc_rewrite", 64'(badvc), 64'(0));
        chk("two_error", 64'(error_o), 64'(0));

        // Reset in the middle of a packet
        step(1'b1, 0, HEAD, 1, '0, nvc);
        step(1'b1, 0, BODY, 2, '0, nvc);
        do_reset();
        chk("midrst_empty", 64'(is_empty_o), 64'({VC_NUM{1'b1}}));
        chk("midrst_alloc", 64'(is_allocatable_vc_o), 64'({VC_NUM{1'b1}}));

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) do_reset();
            w  = $urandom_range(0, VC_NUM - 1);
            vf = ($urandom_range(0, 99) < 60);
            if (mq[w].size() >= B - 1 && $urandom_range(0, 99) < 90) vf = 1'b0;
            if ($urandom_range(0, 99) < 5)
                l = flit_label_t'($urandom_range(0, 3));
            else if (mst[w] == 0)
                l = ($urandom_range(0, 99) < 75) ? HEAD : HEADTAIL;
            else
                l = ($urandom_range(0, 99) < 25) ? TAIL : BODY;
            rr  = (rr + 1) % VC_NUM;
            sel = pick_sel(rr);
            sav = can_pop(sel) && ($urandom_range(0, 99) < 80);
            if ($urandom_range(0, 99) < 4) begin
                sel = $urandom_range(0, VC_NUM - 1);
                sav = 1'b1;
            end
            for (int k = 0; k < VC_NUM; k++) begin
                vav[k] = ($urandom_range(0, 99) < 30);
                nvc[k] = VC_SIZE'($urandom_range(0, VC_NUM - 1));
            end
            cyc(vf, mkf(w, l, $urandom_range(0, MESH_SIZE_X - 1), $urandom_range(0, MESH_SIZE_Y - 1),
                $urandom_range(0, 65535)), sav, VC_SIZE'(sel), vav, nvc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/input_port.md
# input_port

Router input port: one FIFO and one packet-state machine per virtual channel (VC), plus XY route computation on HEAD flits. It receives flits from the upstream link and raises per-VC VA and SA requests toward the router allocators. It drives the winning VC's head flit onto the crossbar, with `vc_id` rewritten to the allocated downstream VC. Types and constants (`flit_t`, `port_t`, `VC_NUM`, `VC_SIZE`, `flit_label_t`) come from `noc_params`.

## Interface
- `BUFFER_SIZE`, default 8: flits per VC FIFO; power of two, ≥4.
- `X_CURRENT`, default `MESH_SIZE_X/2`: this router's X coordinate.
- `Y_CURRENT`, default `MESH_SIZE_Y/2`: this router's Y coordinate.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `data_i` in `flit_t`: incoming flit; `data_i.vc_id` selects the VC.
- `valid_flit_i` in 1: `data_i` valid this cycle.
- `sa_sel_vc_i` in `VC_SIZE`: VC granted by switch allocation.
- `sa_valid_i` in 1: SA grant valid; pop the selected VC this cycle.
- `va_new_vc_i` in `[VC_NUM][VC_SIZE]`: downstream VC assigned to each VC.
- `va_valid_i` in `VC_NUM`: per-VC VA grant.
- `xb_flit_o` out `flit_t`: flit to crossbar.
- `is_on_off_o` out `VC_NUM`: on/off flow-control credit to upstream (1 = send allowed).
- `is_allocatable_vc_o` out `VC_NUM`: VC is IDLE and empty and can accept a new packet.
- `va_request_o` out `VC_NUM`: VC requests virtual-channel allocation.
- `sa_request_o` out `[VC_NUM]` 1 bit each: VC requests switch allocation.
- `sa_downstream_vc_o` out `[VC_NUM][VC_SIZE]`: latched downstream VC per VC.
- `out_port_o` out `port_t [VC_NUM]`: routed output port per VC.
- `is_full_o`, `is_empty_o` out `VC_NUM`: FIFO status.
- `error_o` out `VC_NUM`: sticky protocol-error flag.

## Operation
- Per-VC FSM states: IDLE, VA, SA.
- IDLE:
  - A HEAD or HEADTAIL write is stored and moves the VC to VA.
  - The same write registers `out_port_o`, using XY routing: `x_dest>X_CURRENT` → EAST; `x_dest<X_CURRENT` → WEST; else `y_dest>Y_CURRENT` → SOUTH; `y_dest<Y_CURRENT` → NORTH; else LOCAL.
- VA:
  - `va_request_o[v]=1`.
  - On `va_valid_i[v]`, latch `va_new_vc_i[v]` into `sa_downstream_vc_o[v]` and go to SA.
  - BODY/TAIL writes are stored; `va_valid_i` in any other state is ignored.
- SA:
  - `sa_request_o[v] = !is_empty_o[v]`.
  - BODY/TAIL writes are stored.
  - Popping a TAIL or HEADTAIL returns the VC to IDLE.
- Illegal writes: the flit is dropped (not stored) and `error_o[v]` sets.
  - BODY/TAIL while IDLE.
  - HEAD/HEADTAIL while VA or SA.
  - Any write to a full FIFO not popped in the same cycle.
- Read:
  - `xb_flit_o` is combinational: the FIFO head of VC `sa_sel_vc_i`, with `vc_id` replaced by `sa_downstream_vc_o[sa_sel_vc_i]`.
  - When `sa_valid_i=1`, that flit pops at the next rising edge.
  - `sa_valid_i` to an empty VC, or to a VC not in SA: no pop, `error_o` sets.
- Simultaneous write and pop on the same VC is legal, including when full; count is unchanged.
- Each VC is fully independent; writes and pops on different VCs in the same cycle are both performed.
- `is_on_off_o[v]=1` iff occupancy ≤ `BUFFER_SIZE-2`.
- `is_allocatable_vc_o[v]` = IDLE && empty.
- `error_o` clears only on reset.

## Timing
- Reset values, applied at the edge where `rst=1`:
  - All FIFOs empty; all FSMs IDLE.
  - `is_empty_o`, `is_on_off_o`, `is_allocatable_vc_o` all ones.
  - `is_full_o`, `va_request_o`, `sa_request_o`, `error_o` all zero.
  - `sa_downstream_vc_o` zero; `out_port_o` LOCAL.
- A reset mid-packet discards all contents.
- HEAD written at edge N:
  - `va_request_o` high after edge N.
  - With `va_valid_i` sampled at edge M, `sa_request_o` is high after M (FIFO non-empty).
  - The earliest pop is at edge M+1.
- One flit per cycle sustained through a VC (write and pop every cycle). A 16-flit packet passes through an 8-deep FIFO with no loss when SA pops every cycle.
- Status outputs (`is_full_o`, `is_empty_o`, `is_on_off_o`, requests) are derived from registered state and update the cycle after the causing edge.

## Test plan
- 4-flit packet (HEAD, BODY, BODY, TAIL) on a random VC, one flit per cycle, `va_valid_i` at cycle 2 with new VC 1, SA continuous from cycle 3 → 4 flits out in order, each with `vc_id=1`, payloads intact; VC returns to IDLE and empty.
- Same packet with 2 idle cycles between flits, SA one cycle after VA → identical output order; `sa_request_o` low whenever the FIFO is empty.
- 16-flit packet, VA at cycle 1, SA every cycle after → all 16 delivered in order, `is_full_o` never asserted, no error.
- HEAD followed by 3 extra HEADs, then 2 BODY and a TAIL → only the first HEAD is stored; output is HEAD, BODY, BODY, TAIL; `error_o` set.
- HEADTAIL single flit → one pop returns the VC to IDLE, `is_allocatable_vc_o=1`.
- From IDLE, write BODY then TAIL → `is_empty_o` stays 1, `error_o[v]=1`.
- Two VCs interleaved (VC0 4 flits, VC1 5 flits, VA at cycles 2 and 3) → each VC delivers its own packet in order with its own downstream VC.
